// File: rtl/rxdata_if.sv
// rtl/rxdata_if.sv - serial input and parsed-word outputs of the rxdata receiver
interface rxdata_if;
    logic        i_uart_rx;
    logic        o_stb;
    logic [31:0] o_data;
    logic        o_err;
    logic        o_busy;

    modport master (input i_uart_rx, output o_stb, output o_data, output o_err, output o_busy);
    modport slave  (output i_uart_rx, input o_stb, input o_data, input o_err, input o_busy);
endinterface

// File: rtl/rxdata.sv
// rtl/rxdata.sv - UART receiver parsing "0x%08x\r\n" hex text into strobed 32-bit words
// RXDATA_PARITY_EN selects 8E1 framing with even-parity checking (default 8N1).
module rxdata #(
    parameter logic [23:0] UART_SETUP = 24'd139
) (
    input  logic     i_clk,
    input  logic     i_reset,
    rxdata_if.master bus
);
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef RXDATA_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic        rx_s1, rx_s2, rx_q;
    state_t      state;
    logic [23:0] baud;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        busy, frame_done, frame_ok;
`ifdef RXDATA_PARITY_EN
    logic        par_ok;
`endif
    logic        byte_valid, byte_bad;
    logic [7:0]  byte_q;
    logic [31:0] acc, data_r;
    logic [3:0]  dcnt;
    logic        stb_r, err_r;
    logic        is_hex;
    logic [3:0]  nibble;

    wire expire = (baud == 24'd0);

    // rx_q lags rx_s2 by one clock so a falling edge can be seen on the synchronised line
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_q  <= 1'b1;
        end else begin
            rx_s1 <= bus.i_uart_rx;
            rx_s2 <= rx_s1;
            rx_q  <= rx_s2;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= S_IDLE;
            baud       <= 24'd0;
            bit_idx    <= 3'd0;
            shreg      <= 8'd0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
`ifdef RXDATA_PARITY_EN
            par_ok     <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            if (!expire)
                baud <= baud - 24'd1;
            case (state)
                S_IDLE: begin
                    if (rx_q && !rx_s2) begin
                        baud  <= UART_SETUP >> 1;
                        busy  <= 1'b1;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (expire) begin
                        if (!rx_s2) begin
                            baud    <= UART_SETUP - 24'd1;
                            bit_idx <= 3'd0;
                            state   <= S_DATA;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (expire) begin
                        shreg   <= {rx_s2, shreg[7:1]};
                        baud    <= UART_SETUP - 24'd1;
                        bit_idx <= bit_idx + 3'd1;
`ifdef RXDATA_PARITY_EN
                        if (bit_idx == 3'd7) state <= S_PARITY;
`else
                        if (bit_idx == 3'd7) state <= S_STOP;
`endif
                    end
                end
`ifdef RXDATA_PARITY_EN
                S_PARITY: begin
                    if (expire) begin
                        par_ok <= ~(^{rx_s2, shreg});
                        baud   <= UART_SETUP - 24'd1;
                        state  <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (expire) begin
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        frame_ok   <= rx_s2;
                        state      <= rx_s2 ? S_IDLE : S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (rx_s2) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // One-stage delay between the stop sample and the parser keeps o_stb/o_err two clocks after it
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            byte_valid <= 1'b0;
            byte_bad   <= 1'b0;
            byte_q     <= 8'd0;
        end else begin
            if (frame_done) byte_q <= shreg;
`ifdef RXDATA_PARITY_EN
            byte_valid <= frame_done & frame_ok & par_ok;
            byte_bad   <= frame_done & ~(frame_ok & par_ok);
`else
            byte_valid <= frame_done & frame_ok;
            byte_bad   <= frame_done & ~frame_ok;
`endif
        end
    end

    always_comb begin
        is_hex = 1'b1;
        nibble = 4'd0;
        if (byte_q >= 8'h30 && byte_q <= 8'h39)
            nibble = byte_q[3:0];
        else if ((byte_q >= 8'h61 && byte_q <= 8'h66) || (byte_q >= 8'h41 && byte_q <= 8'h46))
            nibble = byte_q[3:0] + 4'd9;
        else
            is_hex = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            acc    <= 32'd0;
            dcnt   <= 4'd0;
            data_r <= 32'd0;
            stb_r  <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            stb_r <= 1'b0;
            err_r <= byte_bad;
            if (byte_valid) begin
                if (is_hex) begin
                    acc <= {acc[27:0], nibble};
                    if (dcnt != 4'd8) dcnt <= dcnt + 4'd1;
                end else if (byte_q == 8'h78 || byte_q == 8'h58) begin
                    acc  <= 32'd0;
                    dcnt <= 4'd0;
                end else if (byte_q == CH_CR || byte_q == CH_LF) begin
                    if (dcnt != 4'd0) begin
                        data_r <= acc;
                        stb_r  <= 1'b1;
                        acc    <= 32'd0;
                        dcnt   <= 4'd0;
                    end
                end else begin
                    acc   <= 32'd0;
                    dcnt  <= 4'd0;
                    err_r <= 1'b1;
                end
            end
        end
    end

    assign bus.o_stb  = stb_r;
    assign bus.o_data = data_r;
    assign bus.o_err  = err_r;
    assign bus.o_busy = busy;
endmodule

// File: tb/tb_rxdata.sv
// tb/tb_rxdata.sv - self-checking bench for rxdata: text vectors, corner sequences, random text vs model
module tb_rxdata;
    localparam int S = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    rxdata_if bus();
    rxdata #(.UART_SETUP(24'(S))) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor
    int          stb_cnt, err_cnt, busy_rises, hold_viol, gap_bad, last_gap;
    int          busy_fall_cyc = -100;
    logic [31:0] last_word = 32'd0;
    logic [31:0] stb_q[$];
    logic        busy_d = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            last_word = 32'd0;
            busy_d    = 1'b0;
        end else begin
            if (bus.o_stb) begin
                stb_cnt++;
                stb_q.push_back(bus.o_data);
                last_word = bus.o_data;
                last_gap  = cyc - busy_fall_cyc;
                if (last_gap != 2) gap_bad++;
            end else if (bus.o_data !== last_word) begin
                hold_viol++;
            end
            if (bus.o_err) err_cnt++;
            if (!busy_d && bus.o_busy) busy_rises++;
            if (busy_d && !bus.o_busy) busy_fall_cyc = cyc;
            busy_d = bus.o_busy;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        stb_cnt = 0; err_cnt = 0; busy_rises = 0;
        stb_q.delete();
    endtask

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        bus.i_uart_rx = v;
        repeat (S) @(posedge clk);
        #1;
    endtask

`ifdef RXDATA_PARITY_EN
    bit bad_par_next = 1'b0;
`endif

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef RXDATA_PARITY_EN
        drive_bit((^b) ^ bad_par_next);
`endif
        if (bad_stop) begin
            bus.i_uart_rx = 1'b0;
            repeat (S + 40) @(posedge clk);
            #1;
            drive_bit(1'b1);
        end else begin
            drive_bit(1'b1);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0);
        idle(4 * S);
    endtask

    // Reference model: keeps the received hex digits as a list, value formed on terminator
    logic [3:0]  m_dig[$];
    logic [31:0] m_exp[$];
    int          m_err = 0;

    function automatic void model_byte(input logic [7:0] c);
        int v;
        logic [31:0] w;
        v = -1;
        if (c >= 8'h30 && c <= 8'h39) v = int'(c) - 48;
        else if (c >= 8'h61 && c <= 8'h66) v = int'(c) - 97 + 10;
        else if (c >= 8'h41 && c <= 8'h46) v = int'(c) - 65 + 10;
        if (v >= 0) begin
            m_dig.push_back(4'(v));
            if (m_dig.size() > 8) void'(m_dig.pop_front());
        end else if (c == 8'h78 || c == 8'h58) begin
            m_dig.delete();
        end else if (c == 8'h0D || c == 8'h0A) begin
            if (m_dig.size() > 0) begin
                w = 32'd0;
                foreach (m_dig[i]) w = w * 16 + 32'(m_dig[i]);
                m_exp.push_back(w);
                m_dig.delete();
            end
        end else begin
            m_err++;
            m_dig.delete();
        end
    endfunction

    typedef struct {
        string       txt;
        int          n_stb;
        logic [31:0] word;
        int          n_err;
    } vec_t;
    vec_t vecs[8];

    function automatic void set_vec(input int i, input string t, input int n, input logic [31:0] w, input int e);
        vecs[i].txt = t; vecs[i].n_stb = n; vecs[i].word = w; vecs[i].n_err = e;
    endfunction

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        string hexs;
        logic [7:0] c;
        logic [7:0] five;
        int n;
        hexs = "0123456789abcdefABCDEF";

        set_vec(0, "0x12345678\015\n", 1, 32'h12345678, 0);
        set_vec(1, "0xDEADbeef\n",     1, 32'hDEADBEEF, 0);
        set_vec(2, "0x5\015",          1, 32'h00000005, 0);
        set_vec(3, "0x123456789A\015", 1, 32'h3456789A, 0);
        set_vec(4, "0x12G4\015",       1, 32'h00000004, 1);
        set_vec(5, "0x1F\015",         1, 32'h0000001F, 0);
        set_vec(6, "\015\n0X\n",       0, 32'h0000001F, 0);
        set_vec(7, "0xabcdef\015",     1, 32'h00ABCDEF, 0);

        bus.i_uart_rx = 1'b1;
        stb_cnt = 0; err_cnt = 0; busy_rises = 0; hold_viol = 0; gap_bad = 0; last_gap = 0;
        repeat (3) @(negedge clk);
        check("reset_state", {bus.o_stb, bus.o_err, bus.o_busy, bus.o_data}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        idle(4);
        check("post_reset_state", {bus.o_stb, bus.o_err, bus.o_busy, bus.o_data}, 64'd0);

        for (int v = 0; v < 8; v++) begin
            clear_mon();
            send_str(vecs[v].txt);
            check($sformatf("vec%0d_stb_count", v), stb_cnt, vecs[v].n_stb);
            check($sformatf("vec%0d_data", v), bus.o_data, vecs[v].word);
            check($sformatf("vec%0d_err_count", v), err_cnt, vecs[v].n_err);
            if (v == 0) check("stb_two_clocks_after_stop", last_gap, 2);
        end

        // Framing error followed by a held-low line
        clear_mon();
        send_byte(8'h35, 1'b1);
        idle(2 * S);
        check("break_err_count", err_cnt, 1);
        check("break_stb_count", stb_cnt, 0);
        check("break_busy_rises", busy_rises, 1);
        clear_mon();
        send_str("0x7\015");
        check("after_break_data", bus.o_data, 32'h7);
        check("after_break_stb_count", stb_cnt, 1);

        // Short glitch must not start a frame
        clear_mon();
        bus.i_uart_rx = 1'b0;
        idle(3);
        bus.i_uart_rx = 1'b1;
        idle(2 * S);
        check("glitch_no_output", stb_cnt + err_cnt, 0);
        check("glitch_busy_low", bus.o_busy, 1'b0);

        // Reset during bit 4 of the second '5' of "0x55\r"
        send_byte(8'h30, 1'b0);
        send_byte(8'h78, 1'b0);
        send_byte(8'h35, 1'b0);
        five = 8'h35;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(five[i]);
        bus.i_uart_rx = five[4];
        idle(S / 2);
        @(negedge clk);
        check("busy_mid_frame", bus.o_busy, 1'b1);
        rst = 1'b1;
        bus.i_uart_rx = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("outputs_in_reset", {bus.o_stb, bus.o_err, bus.o_busy, bus.o_data}, 64'd0);
        end
        @(posedge clk); #1 rst = 1'b0;
        idle(S);
        clear_mon();
        send_str("0x9\015");
        check("after_reset_stb_count", stb_cnt, 1);
        check("after_reset_data", bus.o_data, 32'h9);
        check("after_reset_err_count", err_cnt, 0);

`ifdef RXDATA_PARITY_EN
        clear_mon();
        send_byte(8'h30, 1'b0);
        send_byte(8'h78, 1'b0);
        send_byte(8'h31, 1'b0);
        bad_par_next = 1'b1;
        send_byte(8'h33, 1'b0);
        bad_par_next = 1'b0;
        send_str("\015");
        check("parity_err_count", err_cnt, 1);
        check("parity_stb_count", stb_cnt, 1);
        check("parity_data", bus.o_data, 32'h1);
`endif

        // Random text against the reference model
        clear_mon();
        m_dig.delete(); m_exp.delete(); m_err = 0;
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 9))
                4:       c = ($urandom_range(0, 1) != 0) ? 8'h78 : 8'h58;
                5, 6:    c = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
                7:       c = 8'($urandom_range(0, 255));
                default: c = hexs[$urandom_range(0, 21)];
            endcase
            send_byte(c, 1'b0);
            model_byte(c);
            idle($urandom_range(0, S));
        end
        send_byte(8'h0D, 1'b0);
        model_byte(8'h0D);
        idle(4 * S);
        check("random_stb_count", stb_q.size(), m_exp.size());
        n = (stb_q.size() < m_exp.size()) ? stb_q.size() : m_exp.size();
        for (int i = 0; i < n; i++) check($sformatf("random_word%0d", i), stb_q[i], m_exp[i]);
        check("random_err_count", err_cnt, m_err);

        check("data_hold_between_strobes", hold_viol, 0);
        check("all_strobes_two_clocks_after_stop", gap_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
